exu_wb_arb: RTL
===============

Name: exu_wb_arb

Overview:
- Writeback arbiter at the EXU tail; sole producer of the exu_wb_data / exu_wb_rd_addr / exu_wb_rd_wr_en port consumed by IDU1 and the register file.
- Collects results from the ALU, MUL, DIV and LSU units, each through a one-entry holding buffer.
- Selects at most one result per cycle by fixed priority and drives it through a registered writeback port.
- Exports a pending-destination mask and per-source buffer-full flags for hazard and stall logic.

Parameters:
XLEN, 32, data width
REG_FILE_ADDR_WIDTH, 5, register address width; NREG = 2**REG_FILE_ADDR_WIDTH

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
alu_wb_valid  in  1  ALU result valid
alu_wb_rd_addr  in  REG_FILE_ADDR_WIDTH  ALU destination register
alu_wb_data  in  XLEN  ALU result
alu_wb_ready  out  1  ALU result accepted this cycle when valid
mul_wb_valid / mul_wb_rd_addr / mul_wb_data / mul_wb_ready  same widths and meaning, MUL unit
div_wb_valid / div_wb_rd_addr / div_wb_data / div_wb_ready  same widths and meaning, DIV unit
lsu_wb_valid / lsu_wb_rd_addr / lsu_wb_data / lsu_wb_ready  same widths and meaning, LSU load data
exu_wb_data  out  XLEN  writeback data
exu_wb_rd_addr  out  REG_FILE_ADDR_WIDTH  writeback destination
exu_wb_rd_wr_en  out  1  writeback strobe
wb_pending_mask  out  NREG  bit r set: a result for register r is buffered or on the output port
wb_buf_full  out  4  buffer occupied flags, bit order {lsu, div, mul, alu}

Behaviour:
- Reset (rst=1 at a clock edge): all buffers empty.
  - Outputs: exu_wb_rd_wr_en=0, exu_wb_data=0, exu_wb_rd_addr=0, wb_pending_mask=0, wb_buf_full=0.
  - While rst is high, all *_ready=0.
  - Reset mid-operation discards buffered and in-flight results without writing them.
- Priority: DIV > LSU > MUL > ALU.
- Candidate per source: the buffered entry if the buffer is occupied; otherwise the incoming result if valid and rd_addr != 0.
- Each cycle, the highest-priority candidate is registered into the output port.
  - exu_wb_rd_wr_en=1 the next cycle with that candidate's rd_addr and data.
  - If no candidate exists, exu_wb_rd_wr_en=0 and data/addr hold their previous values.
- Latency: an uncontested result presented in cycle N appears on exu_wb_* in cycle N+1 (buffer bypassed).
- ready = ~rst & (~buf_full | buffer selected this cycle). Ready is combinational from state and grant only, never from the same source's valid.
- Acceptance happens when valid & ready.
  - An accepted, non-selected incoming result loads the buffer.
  - If the buffer is selected and a new result is accepted in the same cycle, the new result loads the buffer (back-to-back throughput of 1 per cycle per source while winning).
- rd_addr == 0:
  - Accepted when ready, then discarded.
  - Never buffered, never granted, never sets a pending bit.
  - exu_wb_rd_wr_en is never 1 with exu_wb_rd_addr == 0.
- Same rd in two sources simultaneously: priority order decides. Cross-unit WAW ordering is guaranteed upstream by IDU1 stall rules, so the block does not reorder or merge. Within one source, results retire in acceptance order.
- wb_pending_mask (from state only):
  - OR over occupied buffers of onehot(rd_addr)
  - OR onehot(exu_wb_rd_addr) when exu_wb_rd_wr_en=1
- Starvation: a lower-priority buffer waits while higher-priority sources present results every cycle. No fairness is provided; the upstream unit is throttled by its ready signal.
- No internal storage beyond 4 buffers (valid + rd + data each) and the output register.

Test Plan:
- Single result, uncontested: alu_wb_valid=1, rd=5, data=0x1234 in cycle N, ready=1 → cycle N+1: wr_en=1, rd_addr=5, data=0x1234, wb_pending_mask bit 5 set; cycle N+2: wr_en=0.
- Full collision: all four valid in the same cycle with rd=1,2,3,4 (alu, mul, div, lsu) → writebacks on N+1..N+4 in order rd 3, 4, 2, 1. wb_buf_full=4'b1011 at N+1 and clears as each drains. *_ready=0 for non-draining full buffers.
- Backpressure streaming: DIV valid every cycle, with MUL valid held at rd=7 / 0xAA → MUL buffer fills, mul_wb_ready=0 and the MUL data is unchanged while DIV streams. After DIV drops valid, rd 7 / 0xAA is written the next cycle.
- x0 drop: lsu_wb_valid=1, rd=0, data=0xFFFF_FFFF → lsu_wb_ready=1, no wr_en pulse, mask stays 0, wb_buf_full[3]=0.
- Reset mid-operation: rst=1 with 3 buffers occupied → next cycle wb_buf_full=0, mask=0, wr_en=0, all readies 0 while rst is high. The first post-reset result writes with latency 1.
- Same-source back-to-back: ALU rd=8 then rd=9 on consecutive cycles while MUL competes once → rd order 8 then 9 preserved on exu_wb_*.

Source files
------------

// File: rtl/exu_wb_arb_if.sv
// Writeback arbiter bus bundle: the four unit result channels plus the
// registered writeback port and hazard/stall status outputs.
interface exu_wb_arb_if #(
    parameter int XLEN                = 32,
    parameter int REG_FILE_ADDR_WIDTH = 5
);
    localparam int NREG = 2 ** REG_FILE_ADDR_WIDTH;

    logic                           alu_wb_valid;
    logic [REG_FILE_ADDR_WIDTH-1:0] alu_wb_rd_addr;
    logic [XLEN-1:0]                alu_wb_data;
    logic                           alu_wb_ready;

    logic                           mul_wb_valid;
    logic [REG_FILE_ADDR_WIDTH-1:0] mul_wb_rd_addr;
    logic [XLEN-1:0]                mul_wb_data;
    logic                           mul_wb_ready;

    logic                           div_wb_valid;
    logic [REG_FILE_ADDR_WIDTH-1:0] div_wb_rd_addr;
    logic [XLEN-1:0]                div_wb_data;
    logic                           div_wb_ready;

    logic                           lsu_wb_valid;
    logic [REG_FILE_ADDR_WIDTH-1:0] lsu_wb_rd_addr;
    logic [XLEN-1:0]                lsu_wb_data;
    logic                           lsu_wb_ready;

    logic [XLEN-1:0]                exu_wb_data;
    logic [REG_FILE_ADDR_WIDTH-1:0] exu_wb_rd_addr;
    logic                           exu_wb_rd_wr_en;
    logic [NREG-1:0]                wb_pending_mask;
    logic [3:0]                     wb_buf_full;

    // Arbiter side: consumes unit results, produces writeback and status.
    modport slave (
        input  alu_wb_valid, alu_wb_rd_addr, alu_wb_data,
        input  mul_wb_valid, mul_wb_rd_addr, mul_wb_data,
        input  div_wb_valid, div_wb_rd_addr, div_wb_data,
        input  lsu_wb_valid, lsu_wb_rd_addr, lsu_wb_data,
        output alu_wb_ready, mul_wb_ready, div_wb_ready, lsu_wb_ready,
        output exu_wb_data, exu_wb_rd_addr, exu_wb_rd_wr_en,
        output wb_pending_mask, wb_buf_full
    );

    // Producer side: the execution units and the writeback consumers.
    modport master (
        output alu_wb_valid, alu_wb_rd_addr, alu_wb_data,
        output mul_wb_valid, mul_wb_rd_addr, mul_wb_data,
        output div_wb_valid, div_wb_rd_addr, div_wb_data,
        output lsu_wb_valid, lsu_wb_rd_addr, lsu_wb_data,
        input  alu_wb_ready, mul_wb_ready, div_wb_ready, lsu_wb_ready,
        input  exu_wb_data, exu_wb_rd_addr, exu_wb_rd_wr_en,
        input  wb_pending_mask, wb_buf_full
    );
endinterface

// File: rtl/exu_wb_arb.sv
// EXU writeback arbiter: one holding buffer per unit (ALU, MUL, DIV, LSU),
// fixed priority DIV > LSU > MUL > ALU, single registered writeback port.
// Source index order 0..3 = {alu, mul, div, lsu} matches wb_buf_full bits.
module exu_wb_arb #(
    parameter int XLEN                = 32,
    parameter int REG_FILE_ADDR_WIDTH = 5
) (
    input  logic         clk,
    input  logic         rst,
    exu_wb_arb_if.slave  bus
);
    localparam int AW      = REG_FILE_ADDR_WIDTH;
    localparam int NREG    = 2 ** REG_FILE_ADDR_WIDTH;
    localparam int NSRC    = 4;
    localparam int SRC_ALU = 0;
    localparam int SRC_MUL = 1;
    localparam int SRC_DIV = 2;
    localparam int SRC_LSU = 3;

    // Incoming results gathered into index-addressable arrays
    logic [NSRC-1:0] in_valid;
    logic [AW-1:0]   in_rd   [NSRC];
    logic [XLEN-1:0] in_data [NSRC];

    assign in_valid = {bus.lsu_wb_valid, bus.div_wb_valid,
                       bus.mul_wb_valid, bus.alu_wb_valid};
    assign in_rd[SRC_ALU]   = bus.alu_wb_rd_addr;
    assign in_rd[SRC_MUL]   = bus.mul_wb_rd_addr;
    assign in_rd[SRC_DIV]   = bus.div_wb_rd_addr;
    assign in_rd[SRC_LSU]   = bus.lsu_wb_rd_addr;
    assign in_data[SRC_ALU] = bus.alu_wb_data;
    assign in_data[SRC_MUL] = bus.mul_wb_data;
    assign in_data[SRC_DIV] = bus.div_wb_data;
    assign in_data[SRC_LSU] = bus.lsu_wb_data;

    // Holding buffers and the writeback output register
    logic [NSRC-1:0] buf_valid_reg;
    logic [AW-1:0]   buf_rd_reg   [NSRC];
    logic [XLEN-1:0] buf_data_reg [NSRC];

    logic            wb_wr_en_reg;
    logic [AW-1:0]   wb_rd_reg;
    logic [XLEN-1:0] wb_data_reg;

    // Per-source candidate / handshake signals
    logic [NSRC-1:0] in_nz;       // incoming result targets a real register
    logic [NSRC-1:0] cand_valid;
    logic [AW-1:0]   cand_rd   [NSRC];
    logic [XLEN-1:0] cand_data [NSRC];
    logic [NSRC-1:0] grant;
    logic [NSRC-1:0] ready;
    logic [NSRC-1:0] accept;
    logic [NSRC-1:0] buf_free;    // buffer may be rewritten this cycle
    logic [NSRC-1:0] buf_load;    // accepted result must be held for later

    genvar gi;
    generate
        for (gi = 0; gi < NSRC; gi++) begin : g_src
            assign in_nz[gi]      = (in_rd[gi] != '0);
            // An occupied buffer always shadows the incoming result so that
            // results from one unit retire in acceptance order.
            assign cand_valid[gi] = buf_valid_reg[gi] | (in_valid[gi] & in_nz[gi]);
            assign cand_rd[gi]    = buf_valid_reg[gi] ? buf_rd_reg[gi]   : in_rd[gi];
            assign cand_data[gi]  = buf_valid_reg[gi] ? buf_data_reg[gi] : in_data[gi];
            // Ready never looks at this source's own valid, only state and grant.
            assign buf_free[gi]   = ~buf_valid_reg[gi] | grant[gi];
            assign ready[gi]      = ~rst & buf_free[gi];
            assign accept[gi]     = in_valid[gi] & ready[gi];
            // Bypass case: empty buffer and the incoming result itself won.
            assign buf_load[gi]   = accept[gi] & in_nz[gi] &
                                    (buf_valid_reg[gi] | ~grant[gi]);
        end
    endgenerate

    // Fixed priority grant: DIV > LSU > MUL > ALU, no fairness
    always_comb begin
        grant = '0;
        if (cand_valid[SRC_DIV])      grant[SRC_DIV] = 1'b1;
        else if (cand_valid[SRC_LSU]) grant[SRC_LSU] = 1'b1;
        else if (cand_valid[SRC_MUL]) grant[SRC_MUL] = 1'b1;
        else if (cand_valid[SRC_ALU]) grant[SRC_ALU] = 1'b1;
    end

    // Steer the granted candidate onto the writeback register inputs
    logic [AW-1:0]   sel_rd;
    logic [XLEN-1:0] sel_data;
    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (grant[i]) begin
                sel_rd   = cand_rd[i];
                sel_data = cand_data[i];
            end
        end
    end

    // Holding buffer update: drain on grant, refill on non-bypassed accept
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid_reg <= '0;
            for (int i = 0; i < NSRC; i++) begin
                buf_rd_reg[i]   <= '0;
                buf_data_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NSRC; i++) begin
                if (buf_free[i]) begin
                    buf_valid_reg[i] <= buf_load[i];
                    if (buf_load[i]) begin
                        buf_rd_reg[i]   <= in_rd[i];
                        buf_data_reg[i] <= in_data[i];
                    end
                end
            end
        end
    end

    // Writeback port register: strobe each granted cycle, hold addr/data otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_wr_en_reg <= 1'b0;
            wb_rd_reg    <= '0;
            wb_data_reg  <= '0;
        end else if (|grant) begin
            wb_wr_en_reg <= 1'b1;
            wb_rd_reg    <= sel_rd;
            wb_data_reg  <= sel_data;
        end else begin
            wb_wr_en_reg <= 1'b0;
        end
    end

    // Pending destinations: occupied buffers plus the result on the port
    logic [NREG-1:0] pending_mask;
    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (buf_valid_reg[i]) pending_mask[buf_rd_reg[i]] = 1'b1;
        end
        if (wb_wr_en_reg) pending_mask[wb_rd_reg] = 1'b1;
    end

    assign bus.alu_wb_ready    = ready[SRC_ALU];
    assign bus.mul_wb_ready    = ready[SRC_MUL];
    assign bus.div_wb_ready    = ready[SRC_DIV];
    assign bus.lsu_wb_ready    = ready[SRC_LSU];
    assign bus.exu_wb_data     = wb_data_reg;
    assign bus.exu_wb_rd_addr  = wb_rd_reg;
    assign bus.exu_wb_rd_wr_en = wb_wr_en_reg;
    assign bus.wb_pending_mask = pending_mask;
    assign bus.wb_buf_full     = buf_valid_reg;
endmodule
